// File: rtl/rr2ex_pkg.sv
// Shared definitions for the RR->EX skid stage.
// Control-word field positions and the entry width helper.
package rr2ex_pkg;

    localparam int CTRL_W = 10;

    // {A3_sel[9:8], Wr_En, ALU_Src2, ALU_Oper[5:3], D3_Sel[2:1], MEM_Wr_En}
    localparam int MEM_WR_BIT   = 0;
    localparam int D3_SEL_LSB   = 1;
    localparam int D3_SEL_MSB   = 2;
    localparam int ALU_OPER_LSB = 3;
    localparam int ALU_OPER_MSB = 5;
    localparam int ALU_SRC2_BIT = 6;
    localparam int WR_EN_BIT    = 7;
    localparam int A3_SEL_LSB   = 8;
    localparam int A3_SEL_MSB   = 9;

    function automatic int entry_w(input int num_ops, input int data_w,
                                   input int addr_w, input int ctrl_w);
        return num_ops * (data_w + addr_w) + ctrl_w + 1;
    endfunction

endpackage

// File: rtl/rr2ex_snoop_entry.sv
// One pipeline entry register with load, clear and WB snoop.
// Held or freshly loaded operands pick up matching WB writes.
module rr2ex_snoop_entry
    import rr2ex_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int NUM_OPS = 2,
    parameter int CTRL_W  = rr2ex_pkg::CTRL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      clear,
    input  logic                      ld_v,
    input  logic [NUM_OPS*DATA_W-1:0] ld_data,
    input  logic [NUM_OPS*ADDR_W-1:0] ld_addr,
    input  logic [CTRL_W-1:0]         ld_ctrl,
    input  logic                      wb_wr_en,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    output logic                      v,
    output logic [NUM_OPS*DATA_W-1:0] data,
    output logic [NUM_OPS*ADDR_W-1:0] addr,
    output logic [CTRL_W-1:0]         ctrl
);

    logic [NUM_OPS*DATA_W-1:0] src_data;
    logic [NUM_OPS*ADDR_W-1:0] src_addr;
    logic [NUM_OPS*DATA_W-1:0] snp_data;

    always_comb begin
        src_data = load ? ld_data : data;
        src_addr = load ? ld_addr : addr;
        snp_data = src_data;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (wb_wr_en && src_addr[i*ADDR_W +: ADDR_W] == wb_addr) begin
                snp_data[i*DATA_W +: DATA_W] = wb_data;
            end
        end
    end

    // Emptying keeps data/addr so the EX side sees the last operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v    <= 1'b0;
            data <= '0;
            addr <= '0;
            ctrl <= '0;
        end else if (clear) begin
            v    <= 1'b0;
            ctrl <= '0;
        end else if (load) begin
            v <= ld_v;
            if (ld_v) begin
                data <= snp_data;
                addr <= ld_addr;
                ctrl <= ld_ctrl;
            end else begin
                ctrl <= '0;
            end
        end else if (v) begin
            data <= snp_data;
        end
    end

endmodule

// File: rtl/rr2ex_skid_stage.sv
// RR->EX stage: main entry M feeding EX plus skid entry S.
// in_ready is registered (~S.v); flush drops everything.
module rr2ex_skid_stage
    import rr2ex_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int NUM_OPS = 2,
    parameter int CTRL_W  = rr2ex_pkg::CTRL_W,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_OPS*DATA_W-1:0] in_data,
    input  logic [NUM_OPS*ADDR_W-1:0] in_addr,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic                      wb_wr_en,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OPS*DATA_W-1:0] out_data,
    output logic [NUM_OPS*ADDR_W-1:0] out_addr,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int DW      = NUM_OPS * DATA_W;
    localparam int AW      = NUM_OPS * ADDR_W;
    localparam int ENTRY_W = entry_w(NUM_OPS, DATA_W, ADDR_W, CTRL_W);

    logic              m_v;
    logic [DW-1:0]     m_data;
    logic [AW-1:0]     m_addr;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_v;
    logic [DW-1:0]     s_data;
    logic [AW-1:0]     s_addr;
    logic [CTRL_W-1:0] s_ctrl;

    logic               accept;
    logic               drain;
    logic               m_load;
    logic               s_load;
    logic               s_ld_v;
    logic [ENTRY_W-1:0] in_ent;
    logic [ENTRY_W-1:0] s_ent;
    logic [ENTRY_W-1:0] m_src;

    assign accept = in_valid & ~s_v;
    assign drain  = m_v & out_ready;
    assign m_load = ~m_v | drain;

    // S always refills M first so ordering stays FIFO.
    assign in_ent = {accept, in_ctrl, in_addr, in_data};
    assign s_ent  = {s_v, s_ctrl, s_addr, s_data};
    assign m_src  = s_v ? s_ent : in_ent;

    assign s_load = m_load | accept;
    assign s_ld_v = ~m_load & accept;

    rr2ex_snoop_entry #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_OPS(NUM_OPS),
        .CTRL_W (CTRL_W)
    ) u_m (
        .clk     (clk),
        .rst     (rst),
        .load    (m_load),
        .clear   (flush),
        .ld_v    (m_src[ENTRY_W-1]),
        .ld_data (m_src[DW-1:0]),
        .ld_addr (m_src[DW +: AW]),
        .ld_ctrl (m_src[DW+AW +: CTRL_W]),
        .wb_wr_en(wb_wr_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .v       (m_v),
        .data    (m_data),
        .addr    (m_addr),
        .ctrl    (m_ctrl)
    );

    rr2ex_snoop_entry #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_OPS(NUM_OPS),
        .CTRL_W (CTRL_W)
    ) u_s (
        .clk     (clk),
        .rst     (rst),
        .load    (s_load),
        .clear   (flush),
        .ld_v    (s_ld_v),
        .ld_data (in_data),
        .ld_addr (in_addr),
        .ld_ctrl (in_ctrl),
        .wb_wr_en(wb_wr_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .v       (s_v),
        .data    (s_data),
        .addr    (s_addr),
        .ctrl    (s_ctrl)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (m_v && !out_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = ~s_v;
    assign out_valid = m_v;
    assign out_data  = m_data;
    assign out_addr  = m_addr;
    assign out_ctrl  = m_v ? m_ctrl : '0;

endmodule

// File: tb/tb_rr2ex_skid_stage.sv
// Bench for rr2ex_skid_stage: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_rr2ex_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [5:0]  in_addr;
    logic [9:0]  in_ctrl;
    logic        wb_wr_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_ready;

    logic        in_ready, in_ready2;
    logic        out_valid, out_valid2;
    logic [31:0] out_data, out_data2;
    logic [5:0]  out_addr, out_addr2;
    logic [9:0]  out_ctrl, out_ctrl2;
    logic [7:0]  stall_cnt;
    logic [1:0]  stall_cnt2;

    always #5 clk = ~clk;

    rr2ex_skid_stage #(
        .DATA_W(16), .ADDR_W(3), .NUM_OPS(2), .CTRL_W(10), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_ctrl(in_ctrl),
        .wb_wr_en(wb_wr_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    rr2ex_skid_stage #(
        .DATA_W(16), .ADDR_W(3), .NUM_OPS(2), .CTRL_W(10), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_addr(in_addr), .in_ctrl(in_ctrl),
        .wb_wr_en(wb_wr_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_addr(out_addr2), .out_ctrl(out_ctrl2),
        .stall_cnt(stall_cnt2)
    );

    typedef struct packed {
        logic        iv;
        logic [31:0] d;
        logic [5:0]  a;
        logic [9:0]  c;
        logic        ordy;
        logic        fl;
        logic        wbe;
        logic [2:0]  wba;
        logic [15:0] wbd;
    } stim_t;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  addr;
        logic [9:0]  ctrl;
    } ent_t;

    typedef struct {
        stim_t       s;
        logic        ev;
        logic [15:0] ed;
        logic        er;
        logic [7:0]  ec;
    } row_t;

    ent_t        q[$];
    int unsigned mcnt;
    logic [31:0] last_d;
    logic [5:0]  last_a;
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    row_t        rows[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
    endtask

    function automatic stim_t mk(input logic iv, input logic [15:0] d0, input logic ordy);
        stim_t s;
        s = '0;
        s.iv = iv;
        s.d = {~d0, d0};
        s.a = {3'd2, 3'd1};
        s.c = 10'h155 ^ {2'b00, d0[7:0]};
        s.ordy = ordy;
        return s;
    endfunction

    function automatic ent_t snoop(input ent_t e, input stim_t s);
        ent_t r;
        r = e;
        for (int i = 0; i < 2; i++)
            if (s.wbe && e.addr[i*3 +: 3] == s.wba) r.data[i*16 +: 16] = s.wbd;
        return r;
    endfunction

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        q.delete();
        mcnt = 0;
        last_d = '0;
        last_a = '0;
    endtask

    // Two-deep FIFO view of the stage, evaluated for the coming edge.
    task automatic model_step(input stim_t s);
        ent_t n;
        bit acc, drn;
        if (q.size() > 0 && !s.ordy) mcnt++;
        if (s.fl) begin
            q.delete();
        end else begin
            acc = s.iv && q.size() < 2;
            drn = q.size() > 0 && s.ordy;
            foreach (q[i]) q[i] = snoop(q[i], s);
            if (drn) void'(q.pop_front());
            if (acc) begin
                n.data = s.d;
                n.addr = s.a;
                n.ctrl = s.c;
                q.push_back(snoop(n, s));
            end
        end
        if (q.size() > 0) begin
            last_d = q[0].data;
            last_a = q[0].addr;
        end
    endtask

    task automatic check_model();
        logic [9:0] ectrl;
        ectrl = (q.size() > 0) ? q[0].ctrl : 10'd0;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_ctrl", 64'(out_ctrl), 64'(ectrl));
        chk("out_data", 64'(out_data), 64'(last_d));
        chk("out_addr", 64'(out_addr), 64'(last_a));
        chk("stall_cnt", 64'(stall_cnt), 64'(umin(mcnt, 255)));
        chk("stall_cnt2", 64'(stall_cnt2), 64'(umin(mcnt, 3)));
    endtask

    task automatic drive(input stim_t s);
        in_valid  = s.iv;
        in_data   = s.d;
        in_addr   = s.a;
        in_ctrl   = s.c;
        out_ready = s.ordy;
        flush     = s.fl;
        wb_wr_en  = s.wbe;
        wb_addr   = s.wba;
        wb_data   = s.wbd;
    endtask

    task automatic cycle(input stim_t s);
        drive(s);
        model_step(s);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_model();
        rst = 1'b1;
    endtask

    initial begin
        stim_t s, prev;

        for (int k = 0; k < 8; k++) begin
            rows[k].s = mk(1'b1, 16'(k + 1), 1'b1);
            rows[k].ev = 1'b1; rows[k].ed = 16'(k + 1); rows[k].er = 1'b1; rows[k].ec = 8'd0;
        end
        rows[8]  = '{mk(1'b0, 16'h0000, 1'b1), 1'b0, 16'h0008, 1'b1, 8'd0};
        rows[9]  = '{mk(1'b1, 16'h00A0, 1'b0), 1'b1, 16'h00A0, 1'b1, 8'd0};
        rows[10] = '{mk(1'b1, 16'h00B0, 1'b0), 1'b1, 16'h00A0, 1'b0, 8'd1};
        rows[11] = '{mk(1'b1, 16'h00C0, 1'b0), 1'b1, 16'h00A0, 1'b0, 8'd2};
        rows[12] = '{mk(1'b1, 16'h00C0, 1'b0), 1'b1, 16'h00A0, 1'b0, 8'd3};
        rows[13] = '{mk(1'b1, 16'h00C0, 1'b1), 1'b1, 16'h00B0, 1'b1, 8'd3};
        rows[14] = '{mk(1'b1, 16'h00C0, 1'b1), 1'b1, 16'h00C0, 1'b1, 8'd3};
        rows[15] = '{mk(1'b0, 16'h0000, 1'b1), 1'b0, 16'h00C0, 1'b1, 8'd3};

        rst = 1'b0;
        drive(mk(1'b0, 16'h0, 1'b1));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        foreach (rows[i]) begin
            cycle(rows[i].s);
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(rows[i].ev));
            chk($sformatf("tbl%0d_data", i), 64'(out_data[15:0]), 64'(rows[i].ed));
            chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(rows[i].er));
            chk($sformatf("tbl%0d_cnt", i), 64'(stall_cnt), 64'(rows[i].ec));
        end

        // Reset while both entries are full and the counter is running.
        do_reset();
        cycle(mk(1'b1, 16'h0A01, 1'b0));
        cycle(mk(1'b1, 16'h0A02, 1'b0));
        repeat (4) cycle(mk(1'b1, 16'h0A03, 1'b0));
        chk("stall5", 64'(stall_cnt), 64'd5);
        cycle(mk(1'b1, 16'h0A03, 1'b0));
        chk("sat_cnt2", 64'(stall_cnt2), 64'd3);
        chk("stall6", 64'(stall_cnt), 64'd6);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_cnt2", 64'(stall_cnt2), 64'd0);
        rst = 1'b1;

        // Flush with both entries full and an input pending.
        cycle(mk(1'b1, 16'h0F01, 1'b0));
        cycle(mk(1'b1, 16'h0F02, 1'b0));
        chk("fl_full", 64'(in_ready), 64'd0);
        s = mk(1'b1, 16'h0F03, 1'b0);
        s.fl = 1'b1;
        cycle(s);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ctrl", 64'(out_ctrl), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        cycle(mk(1'b0, 16'h0, 1'b1));
        chk("fl_gone", 64'(out_valid), 64'd0);
        s = mk(1'b1, 16'h0F04, 1'b1);
        s.fl = 1'b1;
        cycle(s);
        chk("fl_acc_drop", 64'(out_valid), 64'd0);

        // WB snoop on a held entry and on a same-edge skid capture.
        s = mk(1'b1, 16'h0, 1'b0);
        s.d = {16'h3333, 16'h1111};
        s.a = {3'd5, 3'd3};
        cycle(s);
        chk("sn_pre", 64'(out_data[15:0]), 64'h1111);
        s = mk(1'b1, 16'h0, 1'b0);
        s.d = {16'h2222, 16'h4444};
        s.a = {3'd3, 3'd6};
        s.wbe = 1'b1;
        s.wba = 3'd3;
        s.wbd = 16'hBEEF;
        cycle(s);
        chk("sn_m_ch0", 64'(out_data[15:0]), 64'hBEEF);
        chk("sn_m_ch1", 64'(out_data[31:16]), 64'h3333);
        cycle(mk(1'b0, 16'h0, 1'b1));
        chk("sn_s_valid", 64'(out_valid), 64'd1);
        chk("sn_s_ch1", 64'(out_data[31:16]), 64'hBEEF);
        chk("sn_s_ch0", 64'(out_data[15:0]), 64'h4444);
        cycle(mk(1'b0, 16'h0, 1'b1));
        chk("sn_empty", 64'(out_valid), 64'd0);

        // Random traffic; a stalled producer keeps its input stable.
        prev = mk(1'b0, 16'h0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            s = '0;
            s.iv   = $urandom_range(0, 3) != 0;
            s.d    = 32'($urandom);
            s.a    = 6'($urandom);
            s.c    = 10'($urandom);
            s.ordy = $urandom_range(0, 2) != 0;
            s.fl   = $urandom_range(0, 15) == 0;
            s.wbe  = $urandom_range(0, 2) == 0;
            s.wba  = 3'($urandom);
            s.wbd  = 16'($urandom);
            if (q.size() == 2 && prev.iv) begin
                s.iv = 1'b1;
                s.d  = prev.d;
                s.a  = prev.a;
                s.c  = prev.c;
            end
            cycle(s);
            prev = s;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
